// File: rtl/hex_display_ctrl_if.sv
// Bundles the hex display controller's command inputs and display outputs.
// The controller uses the slave modport; whatever drives the commands uses the master modport.
interface hex_display_ctrl_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] value;
   logic                load;
   logic                inc;
   logic                dec;
   logic                blank_lz;
   logic                blink_en;
   logic [4*DIGITS-1:0] value_q;
   logic                ovf;
   logic                unf;
   logic [7*DIGITS-1:0] seg;
   logic                blink_hidden;  // debug view of the blink phase register

   modport master (
      output value, load, inc, dec, blank_lz, blink_en,
      input  value_q, ovf, unf, seg, blink_hidden
   );

   modport slave (
      input  value, load, inc, dec, blank_lz, blink_en,
      output value_q, ovf, unf, seg, blink_hidden
   );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display controller: a loadable up/down hex counter with wrap flags,
// which drives registered active-low seven-segment outputs with leading-zero blanking and blink.
// There is no valid/ready handshake. Each command is sampled at every rising edge, and
// load has priority over inc/dec. seg follows value_q one edge later.
module hex_display_ctrl #(
   parameter int DIGITS    = 4,
   parameter int BLINK_DIV = 25000000
) (
   input logic          clk,
   input logic          rst,
   hex_display_ctrl_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int SW = 7 * DIGITS;
   localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   typedef enum logic {PH_VISIBLE = 1'b0, PH_HIDDEN = 1'b1} phase_t;

   logic [W-1:0]  r_value, w_value_nxt;
   logic          r_ovf, w_ovf_nxt;
   logic          r_unf, w_unf_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   phase_t        r_phase, w_phase_nxt;
   logic [SW-1:0] r_seg, w_seg_nxt;
   logic          w_hide;
   logic          w_above_zero;
   logic [3:0]    w_nib;

   function automatic logic [6:0] f_decode(input logic [3:0] n);
      case (n)
         4'h0: f_decode = 7'b1000000;
         4'h1: f_decode = 7'b1111001;
         4'h2: f_decode = 7'b0100100;
         4'h3: f_decode = 7'b0110000;
         4'h4: f_decode = 7'b0011001;
         4'h5: f_decode = 7'b0010010;
         4'h6: f_decode = 7'b0000010;
         4'h7: f_decode = 7'b1111000;
         4'h8: f_decode = 7'b0000000;
         4'h9: f_decode = 7'b0011000;
         4'hA: f_decode = 7'b0001000;
         4'hB: f_decode = 7'b0000011;
         4'hC: f_decode = 7'b1000110;
         4'hD: f_decode = 7'b0100001;
         4'hE: f_decode = 7'b0000110;
         default: f_decode = 7'b0001110;
      endcase
   endfunction

   // Counter command: inc and dec together cancel out and raise no flag.
   always_comb begin
      w_value_nxt = r_value;
      w_ovf_nxt   = 1'b0;
      w_unf_nxt   = 1'b0;
      if (bus.load) begin
         w_value_nxt = bus.value;
      end else if (bus.inc && !bus.dec) begin
         w_value_nxt = r_value + W'(1);
         w_ovf_nxt   = &r_value;
      end else if (bus.dec && !bus.inc) begin
         w_value_nxt = r_value - W'(1);
         w_unf_nxt   = ~|r_value;
      end
   end

   // Blink phase FSM: toggles after every BLINK_DIV enabled cycles.
   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_phase_nxt = r_phase;
      if (!bus.blink_en) begin
         w_cnt_nxt   = '0;
         w_phase_nxt = PH_VISIBLE;
      end else if (r_cnt == CW'(BLINK_DIV - 1)) begin
         w_cnt_nxt   = '0;
         w_phase_nxt = (r_phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
         w_cnt_nxt = r_cnt + CW'(1);
      end
   end

   // blink_en is gated in directly, so dropping it reveals the display at the very next update.
   assign w_hide = bus.blink_en && (r_phase == PH_HIDDEN);

   always_comb begin
      w_seg_nxt    = '1;
      w_above_zero = 1'b1;
      w_nib        = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         w_nib        = r_value[4*k +: 4];
         w_above_zero = w_above_zero && (w_nib == 4'h0);
         if (bus.blank_lz && w_above_zero && (k != 0))
            w_seg_nxt[7*k +: 7] = 7'b1111111;
         else
            w_seg_nxt[7*k +: 7] = f_decode(w_nib);
      end
      if (w_hide)
         w_seg_nxt = '1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_value <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_cnt   <= '0;
         r_phase <= PH_VISIBLE;
         r_seg   <= '1;
      end else begin
         r_value <= w_value_nxt;
         r_ovf   <= w_ovf_nxt;
         r_unf   <= w_unf_nxt;
         r_cnt   <= w_cnt_nxt;
         r_phase <= w_phase_nxt;
         r_seg   <= w_seg_nxt;
      end
   end

   assign bus.value_q      = r_value;
   assign bus.ovf          = r_ovf;
   assign bus.unf          = r_unf;
   assign bus.seg          = r_seg;
   assign bus.blink_hidden = (r_phase == PH_HIDDEN);
endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Parametrised multi-digit hex display controller for the board's seven-segment bank.
- Holds a DIGITS-nibble value register that can be loaded, incremented or decremented as a hex counter with wrap flags.
- Decodes every nibble to active-low segments, with optional leading-zero blanking and whole-display blinking.
- Sits between datapath/FSM logic and the HEX pins and replaces per-digit combinational decoders.

Parameters:
DIGITS, 4, number of hex digits (1..8); value width is 4*DIGITS.
BLINK_DIV, 25000000, clock cycles per blink half-period (>=2).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous active-low reset.
value  input  4*DIGITS  parallel load value; nibble k = value[4k+3:4k], digit 0 least significant.
load  input  1  capture value into value_q.
inc  input  1  value_q + 1, modulo 16^DIGITS.
dec  input  1  value_q - 1, modulo 16^DIGITS.
blank_lz  input  1  blank leading zero digits.
blink_en  input  1  enable whole-display blink.
value_q  output  4*DIGITS  current held value.
ovf  output  1  one-cycle pulse when inc wraps from all-F to 0.
unf  output  1  one-cycle pulse when dec wraps from 0 to all-F.
seg  output  7*DIGITS  segments; digit k = seg[7k+6:7k], bit 6 = g ... bit 0 = a, 0 = lit.

Behaviour:
- Reset (rst=0 at a rising edge): value_q=0, ovf=0, unf=0, blink counter=0, blink phase=visible, seg=all 1 (dark). Reset overrides every other input.
- Reset is applied mid-count or mid-blink the same way. The first post-reset seg update shows "0" in digit 0, with upper digits following blank_lz.
- Command priority each cycle: load > (inc xor dec).
  - load=1: value_q<=value; inc/dec ignored; ovf/unf stay 0.
  - inc=1 and dec=0: value_q<=value_q+1. If value_q was all-F, result is 0 and ovf=1 for exactly that cycle.
  - dec=1 and inc=0: value_q<=value_q-1. If value_q was 0, result is all-F and unf=1.
  - inc=1 and dec=1 (no load): value_q holds; no flag.
- ovf/unf are registered and asserted in the same cycle the wrapped value_q appears. They are 0 otherwise.
- Decode table (nibble -> g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- seg is registered from the current value_q. Latency: command at edge N updates value_q at N; seg reflects it at edge N+1.
- Leading-zero blanking (blank_lz=1): digit k is blank if it and all digits above it are 0. Digit 0 is never blanked, so value 0 shows a single "0". Example 0x0050 displays as "  50". With blank_lz=0, all digits are shown.
- Blink:
  - While blink_en=1, the counter counts 0..BLINK_DIV-1. At BLINK_DIV-1 it returns to 0 and the phase toggles.
  - In the hidden phase, all seg=1111111. value_q and its updates are unaffected.
  - blink_en=0 clears the counter to 0 and forces the phase to visible on the next edge.
  - blink_en is sampled at the same edge as seg, so blanking follows the registered phase.
- Widths: all arithmetic is 4*DIGITS bits unsigned; no carry out except ovf.

Test Plan:
- DIGITS=4, BLINK_DIV=4. Hold rst=0 for 2 cycles with load=1, value=16'h1234 -> value_q=0, seg=all 1. After release, one edge later seg digit0=1000000.
- Release reset; load 16'hBEEF; 2 cycles later -> seg = {0000011,0000110,0000110,0001110} (digits 3..0); ovf=unf=0.
- Load 16'hFFFE, then inc 2 cycles -> value_q FFFF then 0000; ovf=1 only on the 0000 cycle. Then dec once -> FFFF, unf=1 for one cycle.
- inc=dec=1 for 3 cycles at 16'h0010 -> value_q stays 0010, no flags. Then load=1 with inc=1 and value=16'h0007 -> value_q=0007 (load wins).
- blank_lz=1 with 16'h0050 -> digits 3,2 = 1111111, digit1 = 0010010, digit0 = 1000000. With 16'h0000 -> only digit0 lit (1000000).
- blink_en=1 with 16'h1234 -> seg visible for 4 cycles, all 1 for 4, visible for 4. Drop blink_en mid-hidden -> visible on the next seg update. Issue inc during the hidden phase -> value_q=1235 shown when visible.
